// File: rtl/mul_add_uu.sv
// mul_add_uu: sequential unsigned multiply-add, o_result = A*B + C.
// One multiplier bit per cycle, LSB first, fixed WIDTH-cycle latency.
module mul_add_uu #(
  parameter int WIDTH = 8
) (
  input  logic               i_clk,
  input  logic               reset,
  input  logic               i_enable,
  input  logic [WIDTH-1:0]   i_multiplicand,
  input  logic [WIDTH-1:0]   i_multiplier,
  input  logic [WIDTH-1:0]   i_addend,
  output logic [2*WIDTH-1:0] o_result,
  output logic               o_valid,
  output logic               o_busy
);

  localparam int RW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  // a_q is A pre-shifted by the step count, so the
  // partial product for step n is simply a_q.
  logic [RW-1:0]    a_q;
  // b_q shifts right each step; bit 0 is the current bit.
  logic [WIDTH-1:0] b_q;
  logic [RW-1:0]    acc_q;
  logic [RW-1:0]    acc_sum;
  logic [RW-1:0]    result_q;
  logic [CW-1:0]    cnt_q;
  logic             valid_q;
  logic             start;
  logic             last_step;

  // Next-state decode and step strobes.
  always_comb begin
    state_d   = state_q;
    start     = 1'b0;
    last_step = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (i_enable) begin
          start   = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (cnt_q == LAST) begin
          last_step = 1'b1;
          state_d   = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Accumulator plus this step's partial product.
  // The true sum never exceeds 2^(2W)-2^W, so RW bits
  // hold every intermediate value without wrap.
  always_comb begin
    acc_sum = acc_q;
    if (b_q[0]) begin
      acc_sum = acc_q + a_q;
    end
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Operand capture and shift-add datapath.
  always_ff @(posedge i_clk) begin
    if (reset) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
      cnt_q <= '0;
    end else if (start) begin
      a_q   <= {{WIDTH{1'b0}}, i_multiplicand};
      b_q   <= i_multiplier;
      acc_q <= {{WIDTH{1'b0}}, i_addend};
      cnt_q <= '0;
    end else if (state_q == RUN) begin
      a_q   <= a_q << 1;
      b_q   <= b_q >> 1;
      acc_q <= acc_sum;
      cnt_q <= cnt_q + ONE;
    end
  end

  // Publish the final sum once; hold it until the next.
  always_ff @(posedge i_clk) begin
    if (reset) begin
      result_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (last_step) begin
        result_q <= acc_sum;
        valid_q  <= 1'b1;
      end
    end
  end

  assign o_result = result_q;
  assign o_valid  = valid_q;
  assign o_busy   = (state_q != IDLE);

endmodule

// File: tb/tb_mul_add_uu.sv
// tb_mul_add_uu: randomized self-checking bench for mul_add_uu.
// Checks an 8-bit and a 16-bit instance against A*B+C arithmetic.
module tb_mul_add_uu;

  logic        clk = 1'b0;
  logic        reset;
  logic        en8;
  logic        en16;
  logic [7:0]  a8, b8, c8;
  logic [15:0] a16, b16, c16;
  logic [15:0] r8;
  logic        v8, busy8;
  logic [31:0] r16;
  logic        v16, busy16;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  mul_add_uu #(.WIDTH(8)) dut8 (
    .i_clk          (clk),
    .reset          (reset),
    .i_enable       (en8),
    .i_multiplicand (a8),
    .i_multiplier   (b8),
    .i_addend       (c8),
    .o_result       (r8),
    .o_valid        (v8),
    .o_busy         (busy8)
  );

  mul_add_uu #(.WIDTH(16)) dut16 (
    .i_clk          (clk),
    .reset          (reset),
    .i_enable       (en16),
    .i_multiplicand (a16),
    .i_multiplier   (b16),
    .i_addend       (c16),
    .o_result       (r16),
    .o_valid        (v16),
    .o_busy         (busy16)
  );

  function automatic logic [31:0] model(
    input longint unsigned a,
    input longint unsigned b,
    input longint unsigned c
  );
    longint unsigned p;
    p = a * b + c;
    return p[31:0];
  endfunction

  // Drive one operation and observe it for 21 cycles.
  task automatic run_op(
    input  bit          w16,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic [15:0] c,
    output int          lat,
    output int          vcnt,
    output int          bcnt,
    output logic [31:0] res,
    output bit          leak
  );
    logic [31:0] prev;
    logic [31:0] cur;
    logic        v;
    logic        bz;
    @(negedge clk);
    if (w16) begin
      en16 = 1'b1;
      a16 = a; b16 = b; c16 = c;
      prev = r16;
    end else begin
      en8 = 1'b1;
      a8 = a[7:0]; b8 = b[7:0]; c8 = c[7:0];
      prev = {16'h0, r8};
    end
    @(posedge clk);
    lat = -1; vcnt = 0; bcnt = 0;
    res = '0; leak = 1'b0;
    for (int i = 0; i <= 20; i++) begin
      if (i > 0) @(posedge clk);
      @(negedge clk);
      v   = w16 ? v16 : v8;
      bz  = w16 ? busy16 : busy8;
      cur = w16 ? r16 : {16'h0, r8};
      if (v) begin
        vcnt++;
        if (lat < 0) begin
          lat = i;
          res = cur;
        end
      end
      if (bz) bcnt++;
      if (!v && cur !== prev) leak = 1'b1;
      prev = cur;
      if (i == 0) begin
        en8 = 1'b0; en16 = 1'b0;
        a8  = 8'($urandom);
        b8  = 8'($urandom);
        c8  = 8'($urandom);
        a16 = 16'($urandom);
        b16 = 16'($urandom);
        c16 = 16'($urandom);
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    en8 = 1'b0; en16 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_total++;
    if ({r8, v8, busy8} !== 18'h0) begin
      $display("FAIL reset8 got r=%0d v=%b b=%b want 0/0/0",
               r8, v8, busy8);
    end else n_pass++;
    n_total++;
    if ({r16, v16, busy16} !== 34'h0) begin
      $display("FAIL reset16 got r=%0d v=%b b=%b want 0/0/0",
               r16, v16, busy16);
    end else n_pass++;
    en8 = 1'b1; en16 = 1'b1;
    a8 = 8'd9; b8 = 8'd9; c8 = 8'd9;
    @(posedge clk);
    @(negedge clk);
    n_total++;
    if ({busy8, busy16} !== 2'b00) begin
      $display("FAIL reset_prio got busy=%b%b want 00",
               busy8, busy16);
    end else n_pass++;
    en8 = 1'b0; en16 = 1'b0;
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      a8 = 8'($urandom); b8 = 8'($urandom);
      @(posedge clk);
      @(negedge clk);
    end
    n_total++;
    if ({busy8, v8, r8} !== 18'h0) begin
      $display("FAIL idle_hold got b=%b v=%b r=%0d want 0/0/0",
               busy8, v8, r8);
    end else n_pass++;
  endtask

  task automatic test_basic;
    int lat, vc, bc;
    logic [31:0] res;
    bit leak;
    run_op(1'b0, 16'd2, 16'd5, 16'd1, lat, vc, bc, res, leak);
    n_total++;
    if (res !== 32'd11) begin
      $display("FAIL basic_res got %0d want 11", res);
    end else n_pass++;
    n_total++;
    if (lat !== 8) begin
      $display("FAIL basic_lat got %0d want 8", lat);
    end else n_pass++;
    n_total++;
    if (vc !== 1) begin
      $display("FAIL basic_vcnt got %0d want 1", vc);
    end else n_pass++;
    n_total++;
    if (bc !== 9) begin
      $display("FAIL basic_busy got %0d want 9", bc);
    end else n_pass++;
    n_total++;
    if (leak !== 1'b0) begin
      $display("FAIL basic_hold got leak=%b want 0", leak);
    end else n_pass++;
  endtask

  task automatic test_extremes;
    int lat, vc, bc;
    logic [31:0] res;
    logic [15:0] a, c;
    bit leak;
    run_op(1'b0, 16'd255, 16'd255, 16'd255,
           lat, vc, bc, res, leak);
    n_total++;
    if (res !== 32'd65280 || lat !== 8) begin
      $display("FAIL max8 got %0d lat %0d want 65280 lat 8",
               res, lat);
    end else n_pass++;
    run_op(1'b0, 16'd0, 16'd0, 16'd0, lat, vc, bc, res, leak);
    n_total++;
    if (res !== 32'd0 || lat !== 8 || vc !== 1) begin
      $display("FAIL zero8 got %0d lat %0d v %0d want 0 8 1",
               res, lat, vc);
    end else n_pass++;
    a = 16'($urandom_range(1, 255));
    c = 16'($urandom_range(0, 255));
    run_op(1'b0, a, 16'd0, c, lat, vc, bc, res, leak);
    n_total++;
    if (res !== model(a, 0, c) || lat !== 8) begin
      $display("FAIL bzero8 got %0d lat %0d want %0d lat 8",
               res, lat, model(a, 0, c));
    end else n_pass++;
  endtask

  task automatic test_random;
    int lat, vc, bc;
    logic [31:0] res;
    logic [15:0] a, b, c;
    bit leak;
    for (int n = 0; n < 30; n++) begin
      a = 16'($urandom_range(0, 255));
      b = 16'($urandom_range(0, 255));
      c = 16'($urandom_range(0, 255));
      run_op(1'b0, a, b, c, lat, vc, bc, res, leak);
      n_total++;
      if (res !== model(a, b, c) || lat !== 8 ||
          vc !== 1 || leak) begin
        $display("FAIL rand8 %0d*%0d+%0d got %0d lat %0d want %0d lat 8",
                 a, b, c, res, lat, model(a, b, c));
      end else n_pass++;
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0]  oa [30];
    logic [7:0]  ob [30];
    logic [7:0]  oc [30];
    int          pulse_at [$];
    logic [31:0] pulse_res [$];
    int          starts [$];
    int          nxt;
    int          s;
    int          guard;
    nxt = 0;
    for (int i = 0; i < 30; i++) begin
      if (i == nxt) begin
        if (i + 8 < 30) starts.push_back(i);
        nxt = i + 10;
      end
    end
    @(negedge clk);
    for (int i = 0; i < 30; i++) begin
      oa[i] = 8'($urandom);
      ob[i] = 8'($urandom);
      oc[i] = 8'($urandom);
      en8 = 1'b1;
      a8 = oa[i]; b8 = ob[i]; c8 = oc[i];
      @(posedge clk);
      @(negedge clk);
      if (v8) begin
        pulse_at.push_back(i);
        pulse_res.push_back({16'h0, r8});
      end
    end
    en8 = 1'b0;
    n_total++;
    if (pulse_at.size() !== starts.size()) begin
      $display("FAIL b2b_count got %0d want %0d",
               pulse_at.size(), starts.size());
    end else n_pass++;
    for (int j = 0; j < starts.size() &&
         j < pulse_at.size(); j++) begin
      s = starts[j];
      n_total++;
      if (pulse_at[j] !== s + 8 || pulse_res[j] !==
          model(oa[s], ob[s], oc[s])) begin
        $display("FAIL b2b_%0d got edge %0d res %0d want edge %0d res %0d",
                 j, pulse_at[j], pulse_res[j], s + 8,
                 model(oa[s], ob[s], oc[s]));
      end else n_pass++;
    end
    guard = 0;
    while (busy8 && guard < 15) begin
      @(posedge clk);
      @(negedge clk);
      guard++;
    end
    n_total++;
    if (busy8 !== 1'b0) begin
      $display("FAIL b2b_drain got busy=%b want 0", busy8);
    end else n_pass++;
  endtask

  task automatic test_reset_abort;
    bit saw_v;
    int lat;
    logic [31:0] res;
    saw_v = 1'b0;
    @(negedge clk);
    en8 = 1'b1;
    a8 = 8'($urandom_range(1, 255));
    b8 = 8'($urandom_range(1, 255));
    c8 = 8'($urandom);
    @(posedge clk);
    @(negedge clk);
    en8 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (v8) saw_v = 1'b1;
    end
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (v8) saw_v = 1'b1;
    n_total++;
    if ({busy8, v8, r8} !== 18'h0) begin
      $display("FAIL abort_state got b=%b v=%b r=%0d want 0/0/0",
               busy8, v8, r8);
    end else n_pass++;
    reset = 1'b0;
    en8 = 1'b1;
    a8 = 8'd3; b8 = 8'd7; c8 = 8'd2;
    @(posedge clk);
    @(negedge clk);
    en8 = 1'b0;
    n_total++;
    if (busy8 !== 1'b1) begin
      $display("FAIL first_start got busy=%b want 1", busy8);
    end else n_pass++;
    lat = -1;
    res = '0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (v8 && lat < 0) begin
        lat = i;
        res = {16'h0, r8};
      end
    end
    n_total++;
    if (saw_v !== 1'b0) begin
      $display("FAIL abort_valid got pulse=%b want 0", saw_v);
    end else n_pass++;
    n_total++;
    if (res !== 32'd23 || lat !== 8) begin
      $display("FAIL after_abort got %0d lat %0d want 23 lat 8",
               res, lat);
    end else n_pass++;
  endtask

  task automatic test_divider_roundtrip;
    int lat, vc, bc;
    logic [31:0] res;
    bit leak;
    int q, r, dv;
    for (int dd = 5; dd <= 50; dd++) begin
      dv = dd - 3;
      q  = dd / dv;
      r  = dd % dv;
      run_op(1'b0, 16'(q), 16'(dv), 16'(r),
             lat, vc, bc, res, leak);
      n_total++;
      if (res !== 32'(dd) || lat !== 8) begin
        $display("FAIL div_rt %0d/%0d got %0d lat %0d want %0d",
                 dd, dv, res, lat, dd);
      end else n_pass++;
    end
  endtask

  task automatic test_width16;
    int lat, vc, bc;
    logic [31:0] res;
    logic [15:0] a, b, c;
    bit leak;
    run_op(1'b1, 16'hffff, 16'hffff, 16'hffff,
           lat, vc, bc, res, leak);
    n_total++;
    if (res !== 32'd4294901760) begin
      $display("FAIL max16 got %0d want 4294901760", res);
    end else n_pass++;
    n_total++;
    if (lat !== 16 || vc !== 1 || bc !== 17) begin
      $display("FAIL lat16 got lat %0d v %0d b %0d want 16 1 17",
               lat, vc, bc);
    end else n_pass++;
    for (int n = 0; n < 4; n++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      c = 16'($urandom);
      run_op(1'b1, a, b, c, lat, vc, bc, res, leak);
      n_total++;
      if (res !== model(a, b, c) || lat !== 16 || leak) begin
        $display("FAIL rand16 %0d*%0d+%0d got %0d want %0d",
                 a, b, c, res, model(a, b, c));
      end else n_pass++;
    end
  endtask

  initial begin
    reset = 1'b1;
    en8 = 1'b0; en16 = 1'b0;
    a8 = '0; b8 = '0; c8 = '0;
    a16 = '0; b16 = '0; c16 = '0;
    test_reset();
    test_basic();
    test_extremes();
    test_random();
    test_back_to_back();
    test_reset_abort();
    test_divider_roundtrip();
    test_width16();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mul_add_uu.md
MUL_ADD_UU -- requirements
Module: mul_add_uu

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits (legal range 2..32).
REQ-002 SHALL have port i_clk  input  1  clock; all state changes on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port i_enable  input  1  start strobe, sampled only in IDLE.
REQ-005 SHALL have port i_multiplicand  input  WIDTH  unsigned operand A (quotient side).
REQ-006 SHALL have port i_multiplier  input  WIDTH  unsigned operand B (divisor side).
REQ-007 SHALL have port i_addend  input  WIDTH  unsigned operand C (remainder side).
REQ-008 SHALL have port o_result  output  2*WIDTH  unsigned A*B+C, held between operations.
REQ-009 SHALL have port o_valid  output  1  one-cycle pulse marking new o_result.
REQ-010 SHALL have port o_busy  output  1  high whenever state is not IDLE.

Function
REQ-011 SHALL compute o_result = A*B + C exactly; the maximum (2^W-1)^2+(2^W-1) = 2^(2W)-2^W fits 2*WIDTH bits, so no overflow or truncation is permitted.
REQ-012 SHALL implement FSM states IDLE, RUN, DONE.
REQ-013 SHALL, in IDLE with i_enable=1 at edge k, register A, B, C; initialise accumulator to zero-extended C and bit counter to 0; go to RUN.
REQ-014 SHALL, in IDLE with i_enable=0, remain in IDLE with all registers unchanged.
REQ-015 SHALL, in RUN, process one multiplier bit per clock, LSB first: if the current bit is 1, add A shifted left by counter to accumulator; increment counter.
REQ-016 SHALL leave RUN at edge k+WIDTH (after exactly WIDTH bit steps), load o_result with the final accumulator, set o_valid=1, go to DONE.
REQ-017 SHALL, in DONE, return to IDLE at the next edge (k+WIDTH+1) and clear o_valid; o_valid is high for exactly one cycle.
REQ-018 SHALL ignore i_enable and operand inputs in RUN and DONE; input changes after edge k SHALL NOT affect the result.
REQ-019 SHALL give latency WIDTH cycles from capture edge to o_valid high; minimum start-to-start spacing WIDTH+2 cycles (next start accepted at edge k+WIDTH+2).
REQ-020 SHALL hold o_result constant from DONE until the next DONE; o_result SHALL NOT expose partial accumulator values.
REQ-021 SHALL treat B=0 as a normal operation (result = C, same latency); no early termination.
REQ-022 SHALL assert o_busy combinationally from state: 0 in IDLE, 1 in RUN and DONE.

Reset
REQ-023 SHALL, when reset=1 at an edge, force state IDLE, o_valid=0, o_result=0, counter=0, accumulator=0 irrespective of state or i_enable.
REQ-024 SHALL abandon any operation in progress on reset without asserting o_valid for it.
REQ-025 SHALL accept a new start at the first edge with reset=0 and i_enable=1.
REQ-026 SHALL give reset priority over i_enable in the same cycle.

Verification
REQ-027 SHALL cover WIDTH=8: A=2, B=5, C=1 started at edge k -> o_valid high only in cycle after edge k+8, o_result=11, o_busy high edges k..k+8.
REQ-028 SHALL cover WIDTH=8 extremes: A=255, B=255, C=255 -> o_result=65280; A=0, B=0, C=0 -> o_result=0 with same latency.
REQ-029 SHALL cover i_enable held high continuously with operands changing every cycle -> starts only at edges k, k+10, k+20; each result matches operands captured at its start edge.
REQ-030 SHALL cover reset asserted at edge k+4 of a run -> no o_valid pulse, o_result=0, o_busy=0 next cycle; following start A=3, B=7, C=2 -> o_result=23.
REQ-031 SHALL cover divider round-trip: for dividend 5..50 and divisor 2..47 stepping together, feed quotient, divisor, remainder from div_uu -> o_result equals original dividend.
REQ-032 SHALL cover WIDTH=16: A=65535, B=65535, C=65535 -> o_result=4294901760, o_valid 16 cycles after capture.
